// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the execute-stage multiply/divide sequencer.
package muldiv_sequencer_pkg;

  localparam logic [1:0] OPC_ALU = 2'd0;
  localparam logic [1:0] OPC_MUL = 2'd1;
  localparam logic [1:0] OPC_DIV = 2'd2;
  localparam logic [1:0] OPC_RSV = 2'd3;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MUL = 2'd1;
  localparam logic [1:0] RES_DIV = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MUL_START = 3'd1,
    S_MUL_WAIT  = 3'd2,
    S_DIV_START = 3'd3,
    S_DIV_WAIT  = 3'd4,
    S_RETIRE    = 3'd5
  } state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Decode/execute-side bundle of the sequencer; the sequencer sits on the slave modport.
interface muldiv_sequencer_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 op_valid;
  logic [1:0]           op_class;
  logic [1:0]           mult_mode_in;
  logic                 div_mode_in;
  logic                 multiplier_done;
  logic                 divider_done;
  logic                 mult_start;
  logic                 div_start;
  logic [1:0]           mult_mode;
  logic                 div_mode;
  logic [1:0]           execute_result_loc;
  logic                 stall;
  logic                 busy;
  logic                 op_timeout;
  logic [CNT_WIDTH-1:0] mul_count;
  logic [CNT_WIDTH-1:0] div_count;

  modport master (
    output op_valid, op_class, mult_mode_in, div_mode_in, multiplier_done, divider_done,
    input  mult_start, div_start, mult_mode, div_mode, execute_result_loc,
           stall, busy, op_timeout, mul_count, div_count
  );

  modport slave (
    input  op_valid, op_class, mult_mode_in, div_mode_in, multiplier_done, divider_done,
    output mult_start, div_start, mult_mode, div_mode, execute_result_loc,
           stall, busy, op_timeout, mul_count, div_count
  );
endinterface

// File: rtl/muldiv_sequencer_sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences one MUL or DIV at a time: start pulse, stall until done or watchdog,
// then one RETIRE cycle where the result mux still points at the unit.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 128,
  parameter int CNT_WIDTH      = 16
) (
  input logic              clk,
  input logic              reset,
  muldiv_sequencer_if.slave bus
);
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic [1:0]      mult_mode_q, mult_mode_d;
  logic            div_mode_q, div_mode_d;
  logic            mult_start_q, mult_start_d;
  logic            div_start_q, div_start_d;
  logic            stall_q, stall_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic [1:0]      loc_q, loc_d;
  logic            accept_mul, accept_div, mul_inc, div_inc;

  always_comb begin
    // Gated by reset so stall also reads 0 while reset is held.
    accept_mul   = reset && (state_q == S_IDLE) && bus.op_valid && (bus.op_class == OPC_MUL);
    accept_div   = reset && (state_q == S_IDLE) && bus.op_valid && (bus.op_class == OPC_DIV);
    state_d      = state_q;
    wdog_d       = wdog_q;
    mult_mode_d  = mult_mode_q;
    div_mode_d   = div_mode_q;
    timeout_d    = 1'b0;
    mul_inc      = 1'b0;
    div_inc      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_mul || accept_div) begin
          mult_mode_d = bus.mult_mode_in;
          div_mode_d  = bus.div_mode_in;
          state_d     = accept_mul ? S_MUL_START : S_DIV_START;
        end
      end
      // Done may still be high from the previous op, so it is not looked at here.
      S_MUL_START: begin wdog_d = '0; state_d = S_MUL_WAIT; end
      S_DIV_START: begin wdog_d = '0; state_d = S_DIV_WAIT; end
      S_MUL_WAIT: begin
        if (bus.multiplier_done)  begin state_d = S_RETIRE; mul_inc = 1'b1; end
        else if (wdog_q == WD_LAST) begin state_d = S_RETIRE; timeout_d = 1'b1; end
        else                        wdog_d = wdog_q + WD_W'(1);
      end
      S_DIV_WAIT: begin
        if (bus.divider_done)     begin state_d = S_RETIRE; div_inc = 1'b1; end
        else if (wdog_q == WD_LAST) begin state_d = S_RETIRE; timeout_d = 1'b1; end
        else                        wdog_d = wdog_q + WD_W'(1);
      end
      S_RETIRE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are registered off the next state so they line up with it.
    mult_start_d = (state_d == S_MUL_START);
    div_start_d  = (state_d == S_DIV_START);
    stall_d      = (state_d == S_MUL_START) || (state_d == S_MUL_WAIT) ||
                   (state_d == S_DIV_START) || (state_d == S_DIV_WAIT);
    busy_d       = (state_d != S_IDLE);
    case (state_d)
      S_IDLE:      loc_d = RES_ALU;
      S_MUL_START: loc_d = RES_MUL;
      S_DIV_START: loc_d = RES_DIV;
      default:     loc_d = loc_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wdog_q       <= '0;
      mult_mode_q  <= '0;
      div_mode_q   <= 1'b0;
      mult_start_q <= 1'b0;
      div_start_q  <= 1'b0;
      stall_q      <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      loc_q        <= RES_ALU;
    end else begin
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      mult_mode_q  <= mult_mode_d;
      div_mode_q   <= div_mode_d;
      mult_start_q <= mult_start_d;
      div_start_q  <= div_start_d;
      stall_q      <= stall_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      loc_q        <= loc_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_mul_cnt (
    .clk(clk), .reset(reset), .inc(mul_inc), .count(bus.mul_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_div_cnt (
    .clk(clk), .reset(reset), .inc(div_inc), .count(bus.div_count)
  );

  assign bus.stall              = stall_q | accept_mul | accept_div;
  assign bus.mult_start         = mult_start_q;
  assign bus.div_start          = div_start_q;
  assign bus.mult_mode          = mult_mode_q;
  assign bus.div_mode           = div_mode_q;
  assign bus.execute_result_loc = loc_q;
  assign bus.busy               = busy_q;
  assign bus.op_timeout         = timeout_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer: each op's expected per-cycle trace is
// derived from its accept cycle, done cycle and the watchdog limit.
module tb_muldiv_sequencer;
  localparam int TMO  = 12;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.CNT_WIDTH(CW)) bus();

  muldiv_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int m_mul  = 0, m_div = 0, m_mm = 0, m_dm = 0;

  // One instruction from accept (cycle 0) to its last cycle. done_at is the
  // cycle the matching done first rises (outside 2..TMO+1 means timeout).
  task automatic run_op(input int cls, input int done_at, input bit stale,
                        input int hold_cls, input int mm_in);
    int unit, r, mm, dm, mdone, eloc;
    bit to, e_stall, e_busy;
    unit = (cls == 1) ? 1 : (cls == 2) ? 2 : 0;
    mm   = (mm_in < 0) ? int'($urandom_range(0, 3)) : mm_in;
    dm   = int'($urandom_range(0, 1));
    to   = 1'b0;
    if (unit == 0)                            r = 0;
    else if (done_at >= 2 && done_at <= TMO + 1) r = done_at + 1;
    else begin r = TMO + 2; to = 1'b1; end
    for (int c = 0; c <= r; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        bus.op_valid = 1'b1; bus.op_class = 2'(cls);
        bus.mult_mode_in = 2'(mm); bus.div_mode_in = dm[0];
      end else begin
        bus.op_valid     = (hold_cls >= 0) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.op_class     = (hold_cls >= 0) ? 2'(hold_cls) : 2'($urandom_range(0, 3));
        bus.mult_mode_in = 2'($urandom_range(0, 3));
        bus.div_mode_in  = 1'($urandom_range(0, 1));
      end
      if (c < 2)       mdone = stale ? 1 : int'($urandom_range(0, 1));
      else if (c >= r) mdone = int'($urandom_range(0, 1));
      else             mdone = (!to && c == done_at) ? 1 : 0;
      bus.multiplier_done = (unit == 1) ? 1'(mdone) : 1'($urandom_range(0, 1));
      bus.divider_done    = (unit == 2) ? 1'(mdone) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (unit != 0 && c == r && !to) begin
        if (unit == 1) m_mul = (m_mul < CMAX) ? m_mul + 1 : m_mul;
        else           m_div = (m_div < CMAX) ? m_div + 1 : m_div;
      end
      e_stall = (unit != 0) && (c < r);
      e_busy  = (unit != 0) && (c >= 1);
      eloc    = e_busy ? unit : 0;
      n_chk++; if (bus.stall !== e_stall) begin n_fail++;
        $display("FAIL stall cls=%0d cyc=%0d got=%b exp=%b", cls, c, bus.stall, e_stall); end
      n_chk++; if (bus.busy !== e_busy) begin n_fail++;
        $display("FAIL busy cls=%0d cyc=%0d got=%b exp=%b", cls, c, bus.busy, e_busy); end
      n_chk++; if (bus.mult_start !== (unit == 1 && c == 1)) begin n_fail++;
        $display("FAIL mult_start cls=%0d cyc=%0d got=%b", cls, c, bus.mult_start); end
      n_chk++; if (bus.div_start !== (unit == 2 && c == 1)) begin n_fail++;
        $display("FAIL div_start cls=%0d cyc=%0d got=%b", cls, c, bus.div_start); end
      n_chk++; if (bus.execute_result_loc !== 2'(eloc)) begin n_fail++;
        $display("FAIL result_loc cls=%0d cyc=%0d got=%0d exp=%0d", cls, c, bus.execute_result_loc, eloc); end
      n_chk++; if (bus.op_timeout !== (to && c == r)) begin n_fail++;
        $display("FAIL op_timeout cls=%0d cyc=%0d got=%b exp=%b", cls, c, bus.op_timeout, to && c == r); end
      n_chk++; if (bus.mult_mode !== 2'(m_mm) || bus.div_mode !== 1'(m_dm)) begin n_fail++;
        $display("FAIL modes cyc=%0d got=%0d/%0d exp=%0d/%0d", c, bus.mult_mode, bus.div_mode, m_mm, m_dm); end
      n_chk++; if (bus.mul_count !== CW'(m_mul) || bus.div_count !== CW'(m_div)) begin n_fail++;
        $display("FAIL counts cyc=%0d got=%0d/%0d exp=%0d/%0d", c, bus.mul_count, bus.div_count, m_mul, m_div); end
      if (c == 0 && unit != 0) begin m_mm = mm; m_dm = dm; end
    end
  endtask

  task automatic test_reset();
    bus.op_valid = 1'b1; bus.op_class = 2'd1; bus.mult_mode_in = 2'd3; bus.div_mode_in = 1'b1;
    bus.multiplier_done = 1'b1; bus.divider_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if ({bus.mult_start, bus.div_start, bus.stall, bus.busy, bus.op_timeout} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=00000",
        {bus.mult_start, bus.div_start, bus.stall, bus.busy, bus.op_timeout}); end
    n_chk++; if ({bus.mult_mode, bus.div_mode, bus.execute_result_loc, bus.mul_count, bus.div_count} !== '0) begin
      n_fail++; $display("FAIL reset_data got=%b exp=0",
        {bus.mult_mode, bus.div_mode, bus.execute_result_loc, bus.mul_count, bus.div_count}); end
    bus.op_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_alu();
    for (int i = 0; i < 5; i++) run_op(0, 0, 0, -1, -1);
    run_op(3, 0, 0, -1, -1);
  endtask

  task automatic test_mul();
    run_op(1, 6, 0, -1, 2);
    n_chk++; if (bus.mul_count !== CW'(1)) begin n_fail++;
      $display("FAIL mul_first_count got=%0d exp=1", bus.mul_count); end
  endtask

  task automatic test_stale_div();
    run_op(2, 10, 1, -1, -1);
    n_chk++; if (bus.div_count !== CW'(1)) begin n_fail++;
      $display("FAIL div_stale_count got=%0d exp=1", bus.div_count); end
  endtask

  task automatic test_timeout();
    run_op(2, -1, 0, -1, -1);
    n_chk++; if (bus.div_count !== CW'(1)) begin n_fail++;
      $display("FAIL timeout_count got=%0d exp=1", bus.div_count); end
    run_op(1, 3, 0, -1, -1);
    n_chk++; if (bus.mul_count !== CW'(2)) begin n_fail++;
      $display("FAIL after_timeout_count got=%0d exp=2", bus.mul_count); end
  endtask

  task automatic test_done_boundary();
    run_op(1, TMO + 1, 0, -1, -1);
    run_op(2, TMO + 2, 0, -1, -1);
  endtask

  task automatic test_back_to_back();
    run_op(1, 5, 0, 2, -1);
    run_op(2, 7, 0, 1, -1);
    run_op(2, 2, 0, -1, -1);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_class = 2'd1; bus.mult_mode_in = 2'd3; bus.div_mode_in = 1'b1;
    bus.multiplier_done = 1'b0; bus.divider_done = 1'b0;
    repeat (3) begin @(posedge clk); #1; bus.op_valid = 1'b0; end
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++;
      $display("FAIL pre_reset_busy got=%b exp=1", bus.busy); end
    bus.op_valid = 1'b1; bus.op_class = 2'd2;
    #2 reset = 1'b0;
    #1;
    n_chk++; if ({bus.mult_start, bus.div_start, bus.stall, bus.busy, bus.op_timeout} !== 5'b0) begin
      n_fail++; $display("FAIL midreset_ctrl got=%b exp=00000",
        {bus.mult_start, bus.div_start, bus.stall, bus.busy, bus.op_timeout}); end
    n_chk++; if ({bus.mult_mode, bus.div_mode, bus.execute_result_loc, bus.mul_count, bus.div_count} !== '0) begin
      n_fail++; $display("FAIL midreset_data got=%b exp=0",
        {bus.mult_mode, bus.div_mode, bus.execute_result_loc, bus.mul_count, bus.div_count}); end
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    reset = 1'b1;
    m_mul = 0; m_div = 0; m_mm = 0; m_dm = 0;
    run_op(2, 5, 0, -1, -1);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) run_op(1, int'($urandom_range(2, TMO + 1)), 0, -1, -1);
    n_chk++; if (bus.mul_count !== CW'(CMAX)) begin n_fail++;
      $display("FAIL mul_saturate got=%0d exp=%0d", bus.mul_count, CMAX); end
  endtask

  task automatic test_random();
    int cls, d;
    for (int i = 0; i < 60; i++) begin
      cls = int'($urandom_range(0, 3));
      d   = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(2, TMO + 3));
      run_op(cls, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_stale_div();
    test_timeout();
    test_done_boundary();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Execute-stage controller that sequences the multi-cycle multiplier and divider for one instruction at a time.
- Decodes the requested operation class and issues a single-cycle start pulse to the correct unit.
- Holds the pipeline stall until the unit reports done or a watchdog expires, and drives the result-select for the execute result mux.
- Sits between decode/control and the execute datapath; it is the sole driver of mult_start, div_start, stall and execute_result_loc.

Parameters:
TIMEOUT_CYCLES, 128, maximum wait cycles for a unit's done before the operation is forcibly retired
CNT_WIDTH, 16, width of the saturating per-unit completion counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
op_valid  input  1  an instruction is present in execute this cycle
op_class  input  2  0=ALU, 1=MUL, 2=DIV, 3=reserved (treated as ALU)
mult_mode_in  input  2  multiplier mode from decode
div_mode_in  input  1  divider signedness from decode
multiplier_done  input  1  multiplier completion, level or pulse
divider_done  input  1  divider completion, level or pulse
mult_start  output  1  one-cycle start pulse to multiplier
div_start  output  1  one-cycle start pulse to divider
mult_mode  output  2  latched multiplier mode, stable for the whole operation
div_mode  output  1  latched divider mode, stable for the whole operation
execute_result_loc  output  2  0=ALU, 1=multiplier, 2=divider
stall  output  1  hold PC/IF/ID while high
busy  output  1  state is not IDLE
op_timeout  output  1  one-cycle pulse when the watchdog retires an operation
mul_count  output  CNT_WIDTH  completed MUL ops, saturating
div_count  output  CNT_WIDTH  completed DIV ops, saturating

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE.
- Reset values: all outputs 0, mode latches 0, counters 0, watchdog 0.
- States: IDLE, MUL_START, MUL_WAIT, DIV_START, DIV_WAIT, RETIRE.
- IDLE:
  - op_valid with class MUL or DIV: latch the mode inputs; next state is MUL_START or DIV_START.
  - stall=1 combinationally in that same cycle so the instruction is held.
  - ALU, reserved class or op_valid=0: stay in IDLE, stall=0, execute_result_loc=0.
- MUL_START / DIV_START:
  - mult_start or div_start=1 for exactly this cycle; stall=1; watchdog cleared.
  - Done inputs are ignored here, since they may be stale from the previous operation.
  - Next state is the matching WAIT state.
- MUL_WAIT / DIV_WAIT:
  - stall=1; watchdog increments each cycle.
  - Only the matching done input is honoured; the other unit's done is ignored.
  - Matching done=1: go to RETIRE and increment the unit counter, saturating at all-ones.
  - Watchdog reaches TIMEOUT_CYCLES-1 without done: go to RETIRE with op_timeout=1 during the RETIRE cycle; the counter does not increment.
- RETIRE:
  - stall=0; execute_result_loc still selects the unit so the write-back captures the result.
  - op_valid is ignored this cycle, because it is the same held instruction.
  - Next state is IDLE.
  - A back-to-back MUL/DIV is therefore accepted no earlier than the cycle after RETIRE.
- execute_result_loc:
  - 1 from MUL_START through RETIRE of a MUL; 2 from DIV_START through RETIRE of a DIV.
  - 0 in IDLE, including the accept cycle.
- mult_mode and div_mode hold their latched values until the next accept. Decode changes during an operation have no effect.
- Latency: accept at cycle 0, start pulse at cycle 1. If done is first seen at cycle N≥2, RETIRE occurs at N+1. Stall is high for cycles 0..N inclusive.
- busy=1 in every non-IDLE state.
- op_valid dropping mid-operation does not abort; the operation completes or times out.
- Reset asserted mid-operation: immediate return to IDLE, no start pulse, counters cleared.

Decomposition:
- Shared constants header (existing project include):
  - op_class encodings (OPC_ALU/MUL/DIV)
  - execute_result_loc encodings (RES_ALU/MUL/DIV)
  - state encodings
- One natural sub-module, sat_counter (parameter WIDTH; ports clk, reset, inc, count), instantiated twice.
- The watchdog stays inline.

Test Plan:
- ALU op (op_valid=1, op_class=0) for 5 cycles -> stall, mult_start and div_start stay 0; execute_result_loc=0; busy=0.
- MUL, mult_mode_in=2, multiplier_done at cycle 6 -> stall high for cycles 0–6; mult_start only at cycle 1; mult_mode=2 throughout; RETIRE at cycle 7 with execute_result_loc=1; mul_count=1.
- DIV with stale divider_done=1 held in cycles 0–1, true done at cycle 10 -> the stale done is ignored; RETIRE at cycle 11; div_count=1.
- DIV with TIMEOUT_CYCLES=8 and no done -> op_timeout pulse in RETIRE after 8 wait cycles; div_count stays 0; next op is accepted.
- Back-to-back MUL then DIV with op_valid held high -> no re-issue in RETIRE; div_start appears 2 cycles after RETIRE; multiplier_done during DIV_WAIT is ignored.
- reset low during MUL_WAIT -> all outputs 0 immediately; after release, a new DIV operation sequences normally. With CNT_WIDTH=2, 5 MULs saturate mul_count at 3.
